// File: rtl/kbd_controller.sv
// Keyboard scancode front end: handshakes with a PS/2-style receiver, folds the
// E0/F0 prefixes into flags and queues {ext, brk, code} events for the CPU.
module kbd_controller #(
  parameter int DEPTH = 8
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       kb_ready,
  input  logic [7:0] kb_scancode,
  output logic       kb_rdn,
  input  logic       cpu_rd,
  input  logic       ovf_clr,
  output logic [9:0] event_data,
  output logic       fifo_empty,
  output logic [4:0] count,
  output logic       overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        code_q, code_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]        count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [9:0]        mem_q [DEPTH];

  logic              push;
  logic              pop;
  logic              wr_en;
  logic              drop;
  logic [9:0]        wr_data;

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q    <= IDLE;
      code_q     <= 8'h00;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge fclk) begin
    if (!rst && wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    push    = 1'b0;
    wr_data = {ext_q, brk_q, code_q};
    case (state_q)
      IDLE: begin
        if (kb_ready) begin
          code_d  = kb_scancode;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!kb_ready) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (code_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (code_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (code_q == 8'h00 || code_q == 8'hFF) begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else begin
          push  = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop on the same edge frees the head slot, so a push into a full FIFO still fits.
  always_comb begin
    pop        = cpu_rd && (count_q != 5'd0);
    wr_en      = push && ((count_q != DEPTH_C) || pop);
    drop       = push && !wr_en;
    wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 5'd1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 5'd1;
    end
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  assign kb_rdn     = (state_q == ACK);
  assign fifo_empty = (count_q == 5'd0);
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign event_data = (count_q == 5'd0) ? 10'd0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_kbd_controller.sv
// Directed bench for kbd_controller: a queue-based event model is checked every
// cycle, with hand-computed literal expectations at key points.
module tb_kbd_controller;

  localparam int DEPTH = 8;

  logic       fclk = 1'b0;
  logic       rst;
  logic       kb_ready;
  logic [7:0] kb_scancode;
  logic       kb_rdn;
  logic       cpu_rd;
  logic       ovf_clr;
  logic [9:0] event_data;
  logic       fifo_empty;
  logic [4:0] count;
  logic       overflow;

  kbd_controller #(.DEPTH(DEPTH)) dut (
    .fclk       (fclk),
    .rst        (rst),
    .kb_ready   (kb_ready),
    .kb_scancode(kb_scancode),
    .kb_rdn     (kb_rdn),
    .cpu_rd     (cpu_rd),
    .ovf_clr    (ovf_clr),
    .event_data (event_data),
    .fifo_empty (fifo_empty),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 fclk = ~fclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Event model: prefix flags, a queue of pending events and the sticky drop flag.
  logic [9:0] q_m [$];
  bit         ext_m = 1'b0;
  bit         brk_m = 1'b0;
  bit         ovf_m = 1'b0;
  bit         model_valid = 1'b0;
  bit         exp_rdn = 1'b0;
  bit         decode_now = 1'b0;
  logic [7:0] decode_code = 8'h00;

  always @(posedge fclk) begin
    bit         do_push;
    bit         do_pop;
    bit         do_drop;
    logic [9:0] ent;
    do_push = 1'b0;
    ent     = 10'd0;
    if (rst) begin
      q_m.delete();
      ext_m       = 1'b0;
      brk_m       = 1'b0;
      ovf_m       = 1'b0;
      model_valid = 1'b1;
    end else begin
      if (decode_now) begin
        case (decode_code)
          8'hE0:        ext_m = 1'b1;
          8'hF0:        brk_m = 1'b1;
          8'h00, 8'hFF: begin ext_m = 1'b0; brk_m = 1'b0; end
          default: begin
            ent     = {ext_m, brk_m, decode_code};
            do_push = 1'b1;
            ext_m   = 1'b0;
            brk_m   = 1'b0;
          end
        endcase
      end
      do_pop  = cpu_rd && (q_m.size() > 0);
      do_drop = do_push && (q_m.size() == DEPTH) && !do_pop;
      if (do_pop) void'(q_m.pop_front());
      if (do_push && !do_drop) q_m.push_back(ent);
      if (do_drop) ovf_m = 1'b1;
      else if (ovf_clr) ovf_m = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge fclk);
      #1;
      if (model_valid) begin
        check_output("count", 32'(count), 32'(q_m.size()));
        check_output("fifo_empty", 32'(fifo_empty), 32'(q_m.size() == 0));
        check_output("event_data", 32'(event_data), (q_m.size() == 0) ? 32'd0 : 32'(q_m[0]));
        check_output("overflow", 32'(overflow), 32'(ovf_m));
        check_output("kb_rdn", 32'(kb_rdn), 32'(exp_rdn));
      end
    end
  end

  // Receiver drops kb_ready 1+hold cycles after kb_rdn rises; strobes = {ovf_clr, cpu_rd} on the push edge.
  task automatic applyStimulus(input logic [7:0] code, input int hold = 0, input logic [1:0] strobes = 2'b00);
    @(negedge fclk);
    kb_ready    = 1'b1;
    kb_scancode = code;
    @(negedge fclk);
    exp_rdn = 1'b1;
    repeat (1 + hold) @(negedge fclk);
    kb_ready = 1'b0;
    @(negedge fclk);
    exp_rdn     = 1'b0;
    decode_now  = 1'b1;
    decode_code = code;
    cpu_rd      = strobes[0];
    ovf_clr     = strobes[1];
    @(negedge fclk);
    decode_now = 1'b0;
    cpu_rd     = 1'b0;
    ovf_clr    = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge fclk);
    cpu_rd = 1'b1;
    @(negedge fclk);
    cpu_rd = 1'b0;
  endtask

  task automatic pulse_ovf_clr();
    @(negedge fclk);
    ovf_clr = 1'b1;
    @(negedge fclk);
    ovf_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    kb_ready    = 1'b0;
    kb_scancode = 8'h00;
    cpu_rd      = 1'b0;
    ovf_clr     = 1'b0;
    repeat (2) @(negedge fclk);
    rst = 1'b0;
    check_output("reset kb_rdn", 32'(kb_rdn), 32'd0);
    check_output("reset fifo_empty", 32'(fifo_empty), 32'd1);
    check_output("reset event_data", 32'(event_data), 32'd0);
    check_output("reset count", 32'(count), 32'd0);
    check_output("reset overflow", 32'(overflow), 32'd0);

    // Single make code and pop.
    applyStimulus(8'h1C);
    check_output("make event_data", 32'(event_data), 32'h01C);
    check_output("make count", 32'(count), 32'd1);
    check_output("make fifo_empty", 32'(fifo_empty), 32'd0);
    pop_one();
    check_output("pop fifo_empty", 32'(fifo_empty), 32'd1);
    check_output("pop event_data", 32'(event_data), 32'd0);

    // Prefixes in either order.
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    check_output("E0F0 count", 32'(count), 32'd1);
    check_output("E0F0 event", 32'(event_data), 32'h375);
    pop_one();
    applyStimulus(8'hF0);
    applyStimulus(8'hE0);
    applyStimulus(8'h6B);
    check_output("F0E0 event", 32'(event_data), 32'h36B);
    pop_one();
    applyStimulus(8'h1C);
    check_output("pend cleared", 32'(event_data), 32'h01C);
    pop_one();

    // Error code discards the prefix; E1 is an ordinary code.
    applyStimulus(8'hF0);
    applyStimulus(8'hFF);
    applyStimulus(8'h1C);
    check_output("FF clears brk", 32'(event_data), 32'h01C);
    pop_one();
    applyStimulus(8'hE0);
    applyStimulus(8'h00);
    applyStimulus(8'hE1);
    check_output("E1 event", 32'(event_data), 32'h0E1);
    check_output("E1 count", 32'(count), 32'd1);
    pop_one();

    // Overflow: ninth push dropped; clear on the drop edge keeps the flag set.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'(8'h10 + i), 0, (i == 8) ? 2'b10 : 2'b00);
    end
    check_output("full count", 32'(count), 32'd8);
    check_output("full overflow", 32'(overflow), 32'd1);
    check_output("full head", 32'(event_data), 32'h010);
    for (int i = 0; i < 8; i++) begin
      check_output("drain order", 32'(event_data), 32'(8'h10 + i));
      pop_one();
    end
    check_output("drained empty", 32'(fifo_empty), 32'd1);
    pop_one();
    check_output("pop on empty count", 32'(count), 32'd0);
    pulse_ovf_clr();
    check_output("ovf_clr", 32'(overflow), 32'd0);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'(8'h20 + i));
    end
    applyStimulus(8'h28, 0, 2'b01);
    check_output("full rw count", 32'(count), 32'd8);
    check_output("full rw overflow", 32'(overflow), 32'd0);
    check_output("full rw head", 32'(event_data), 32'h021);
    for (int i = 0; i < 8; i++) begin
      check_output("full rw order", 32'(event_data), 32'(8'h21 + i));
      pop_one();
    end

    // Receiver stalls with kb_ready high for 20 cycles.
    applyStimulus(8'h2A, 20);
    check_output("stall event", 32'(event_data), 32'h02A);
    check_output("stall count", 32'(count), 32'd1);
    pop_one();

    // Reset during ACK after a break prefix.
    applyStimulus(8'hF0);
    @(negedge fclk);
    kb_ready    = 1'b1;
    kb_scancode = 8'h33;
    @(negedge fclk);
    exp_rdn  = 1'b1;
    rst      = 1'b1;
    kb_ready = 1'b0;
    @(negedge fclk);
    exp_rdn = 1'b0;
    rst     = 1'b0;
    check_output("reset mid-ACK kb_rdn", 32'(kb_rdn), 32'd0);
    check_output("reset mid-ACK count", 32'(count), 32'd0);
    applyStimulus(8'h1C);
    check_output("post-reset event", 32'(event_data), 32'h01C);
    pop_one();

    repeat (3) @(negedge fclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kbd_controller.md
KBD_CONTROLLER -- requirements
Module: kbd_controller

Interface
REQ-001 Parameter: DEPTH, 8, number of event FIFO entries (power of two, 2..16).
REQ-002 Port: fclk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: kb_ready  input  1  receiver "scancode valid" level, held until acknowledged.
REQ-005 Port: kb_scancode  input  8  receiver scancode, stable while kb_ready=1.
REQ-006 Port: kb_rdn  output  1  acknowledge to receiver; high clears its ready flag.
REQ-007 Port: cpu_rd  input  1  one-cycle pop strobe from CPU bus.
REQ-008 Port: ovf_clr  input  1  one-cycle strobe clearing the overflow flag.
REQ-009 Port: event_data  output  10  FIFO head {ext, brk, code[7:0]}; first-word fall-through.
REQ-010 Port: fifo_empty  output  1  high when FIFO holds no entries; CPU interrupt = ~fifo_empty.
REQ-011 Port: count  output  5  number of stored entries, 0..DEPTH.
REQ-012 Port: overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-013 FSM states: IDLE, ACK, DECODE; the FSM SHALL be a single registered state variable.
REQ-014 IDLE: on kb_ready=1, latch kb_scancode into code_r and go to ACK; otherwise stay.
REQ-015 ACK: kb_rdn=1 (combinational decode of state==ACK, 0 in all other states); go to DECODE on the first edge kb_ready samples 0; stay in ACK, no timeout, while kb_ready=1.
REQ-016 DECODE: lasts exactly one cycle; always returns to IDLE.
REQ-017 DECODE, code_r=0xE0: set ext_pend; push nothing.
REQ-018 DECODE, code_r=0xF0: set brk_pend; push nothing.
REQ-019 DECODE, code_r=0x00 or 0xFF (keyboard error/overrun): push nothing; clear ext_pend and brk_pend.
REQ-020 DECODE, any other code (including 0xE1): push {ext_pend, brk_pend, code_r}; clear both pend flags.
REQ-021 Prefix order is free: E0,F0,x and F0,E0,x both yield ext=1, brk=1.
REQ-022 Latency: with a receiver that drops kb_ready one cycle after kb_rdn rises, fifo_empty falls 3 cycles after the edge that first samples kb_ready=1.
REQ-023 Pop: cpu_rd=1 with count>0 removes the head; event_data shows the next entry on the following cycle. cpu_rd with count=0 is ignored.
REQ-024 Push with count<DEPTH: the entry is written and count increments.
REQ-025 Push with count=DEPTH and no pop: the entry is dropped, count is unchanged, overflow is set on the same edge.
REQ-026 Simultaneous push and pop: the push is accepted even when full; count is unchanged.
REQ-027 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is tracked separately, so full and empty are distinguished.
REQ-028 ovf_clr clears overflow. If a drop occurs on the same edge, overflow stays 1.
REQ-029 event_data is 0 when count=0.

Reset
REQ-030 On a rst=1 edge: state=IDLE, ext_pend=0, brk_pend=0, pointers=0, count=0, overflow=0, code_r=0.
REQ-031 Reset outputs: kb_rdn=0, fifo_empty=1, event_data=0.
REQ-032 Reset mid-ACK: kb_rdn drops the cycle after the reset edge; the pending scancode is abandoned; any partial prefix is lost.

Verification
REQ-033 Make code 0x1C (ready 1 cycle after rdn) -> after 3 cycles, event_data=0x01C, count=1, fifo_empty=0; cpu_rd -> fifo_empty=1.
REQ-034 Sequence E0,F0,0x75 -> exactly one entry, event_data=0x375; both pend flags clear afterwards.
REQ-035 Push 9 codes 0x10..0x18 with DEPTH=8 and no reads -> count=8, overflow=1, head=0x010; 8 pops return 0x010..0x017.
REQ-036 Full FIFO, new code arrives in the same cycle as cpu_rd -> count stays 8, newest entry stored, overflow stays 0.
REQ-037 kb_ready held high 20 cycles after ACK -> kb_rdn high the whole time, no push until kb_ready=0.
REQ-038 Assert rst during ACK after a prior F0 -> kb_rdn=0 next cycle; a later 0x1C is pushed as 0x01C (brk=0).
